floo_wide_link_serializer: RTL and testbench
============================================

# floo_wide_link_serializer

Output-side serializer placed directly downstream of a wide router output port. It takes complete wide flits over a valid/ready handshake and emits each flit as a sequence of narrower physical beats for an off-tile or long-reach link. It has one flit buffer and a beat counter, and sends back-to-back flits without bubbles.

## Interface
Parameters:
- `FlitWidth`, default 600: width of one wide flit payload (`data` field of the wide flit).
- `PhyWidth`, default 64: physical link width per beat.
- `NumBeats`, default `(FlitWidth+PhyWidth-1)/PhyWidth`: beats per flit. Derived; do not override.

Ports (one clock; reset is synchronous and active-low):
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  synchronous active-low reset.
- `valid_i`  in  1  flit valid from the router output.
- `ready_o`  out  1  serializer can accept a flit this cycle.
- `data_i`  in  `FlitWidth`  flit payload.
- `phy_valid_o`  out  1  beat valid.
- `phy_ready_i`  in  1  link accepts the beat.
- `phy_data_o`  out  `PhyWidth`  beat payload.
- `phy_last_o`  out  1  marks the final beat of a flit.
- `phy_parity_o`  out  1  even parity of `phy_data_o`. Always 0 unless the parity feature is compiled in.

## Operation
- Two states:
  - IDLE: buffer empty.
  - SEND: buffer holds one flit and `beat_q` indexes the current beat.
- IDLE:
  - `ready_o=1`, `phy_valid_o=0`.
  - When `valid_i`, latch `data_i` into `buf_q`, set `beat_q=0`, go to SEND.
- SEND:
  - `phy_valid_o=1`.
  - `phy_data_o=buf_q[beat_q*PhyWidth +: PhyWidth]`. Bits beyond `FlitWidth` on the last beat read as 0.
  - `phy_last_o=(beat_q==NumBeats-1)`.
- Beat handshake in SEND (`phy_valid_o && phy_ready_i`):
  - Not last beat: `beat_q` increments.
  - Last beat with `valid_i=1`: load the new flit, set `beat_q=0`, stay in SEND.
  - Last beat with `valid_i=0`: go to IDLE and clear `beat_q` to 0.
- `ready_o = (state==IDLE) || (state==SEND && phy_last_o && phy_ready_i)`.
  - This is a combinational path from `phy_ready_i`.
  - There is no path from `valid_i` to `ready_o`.
- Stall: while `phy_valid_o && !phy_ready_i`, `phy_data_o`, `phy_last_o` and `phy_parity_o` hold stable, and `beat_q` does not change.
- `NumBeats==1`: every beat is last; the block acts as a one-deep pipeline register.
- `beat_q` width is `max(1,$clog2(NumBeats))`. It never exceeds `NumBeats-1`, so there is no wrap-around beyond the last beat.
- `valid_i` may drop while `ready_o=0` without side effects. The serializer does not require upstream valid stability.
- Elaboration assertions: `PhyWidth>=1` and `FlitWidth>=PhyWidth`.

## Timing
- Reset (`rst_ni=0` at a rising edge):
  - state goes to IDLE, `beat_q=0`, `buf_q=0`.
  - Outputs: `phy_valid_o=0`, `phy_last_o=0`, `phy_data_o=0`, `phy_parity_o=0`, `ready_o=1`.
  - Reset mid-flit drops the partially sent flit. No further beats of it are emitted.
- Latency: flit accepted in cycle N; first beat valid in cycle N+1.
- Throughput: one flit per `NumBeats` cycles under continuous `phy_ready_i`, with no idle cycle between flits.
- Simultaneous last-beat handshake and `valid_i`: both transfers complete in the same cycle, and the new flit's beat 0 is driven in the next cycle.

## Configuration
- `FLOO_SER_PARITY_EN` defined:
  - `phy_parity_o = ^phy_data_o`, computed combinationally from the registered beat.
  - It obeys the same stall stability as `phy_data_o`.
- Not defined: `phy_parity_o` is tied to 0 and no parity logic is synthesized. The port list is identical in both builds.

## Test plan
All scenarios use `FlitWidth=200`, `PhyWidth=64`, so `NumBeats=4`.
- Reset: hold `rst_ni=0` for 3 cycles with `valid_i=1` -> `ready_o=1`, `phy_valid_o=0`, all outputs 0, no flit captured.
- Single flit `data_i=200'hA5<<192 | 64'h1111_2222_3333_4444`, `phy_ready_i=1` ->
  - beats on cycles N+1..N+4: `64'h1111_2222_3333_4444`, 0, 0, then `64'h00..00A5`.
  - `phy_last_o` is high only on the 4th beat.
  - Upper 56 bits of the last beat are 0.
- Back-to-back flits with `valid_i` held high and `phy_ready_i=1` -> 8 consecutive valid beats with no gap; `ready_o` pulses exactly on the 4th and 8th cycles.
- Random `phy_ready_i` (50% low) over 100 flits -> scoreboard reassembly matches every input flit in order, and no beat changes while stalled.
- Assert `rst_ni=0` on beat 2 of a flit -> next cycle `phy_valid_o=0`, IDLE, and the following flit starts at beat 0.
- With `FLOO_SER_PARITY_EN`, beat `64'h1` -> `phy_parity_o=1`; beat `64'h3` -> 0. Without the macro: always 0.

Source files
------------

// File: rtl/floo_wide_link_serializer.sv
// Serializes wide router flits into PhyWidth-wide link beats with one flit buffer.
// Optional build macro FLOO_SER_PARITY_EN drives even parity of each beat on phy_parity_o.
module floo_wide_link_serializer #(
    parameter int unsigned FlitWidth = 600,
    parameter int unsigned PhyWidth  = 64,
    parameter int unsigned NumBeats  = (FlitWidth + PhyWidth - 1) / PhyWidth
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [FlitWidth-1:0] data_i,
    output logic                 phy_valid_o,
    input  logic                 phy_ready_i,
    output logic [PhyWidth-1:0]  phy_data_o,
    output logic                 phy_last_o,
    output logic                 phy_parity_o
);

    localparam int unsigned BeatWidth = (NumBeats > 1) ? $clog2(NumBeats) : 1;
    localparam int unsigned PadWidth  = NumBeats * PhyWidth;

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] SEND = 1'b1;

    if (PhyWidth < 1) begin : g_chk_phy_width
        $error("floo_wide_link_serializer: PhyWidth must be at least 1");
    end
    if (FlitWidth < PhyWidth) begin : g_chk_flit_width
        $error("floo_wide_link_serializer: FlitWidth must be at least PhyWidth");
    end

    logic [0:0]           state_q;
    logic [FlitWidth-1:0] buf_q;
    logic [BeatWidth-1:0] beat_q;

    logic [PadWidth-1:0]  buf_pad;
    logic [PhyWidth-1:0]  beat_words [NumBeats];
    logic                 last_beat;
    logic                 beat_fire;
    logic                 accept;

    // Zero-extend so the final beat reads 0 above FlitWidth.
    assign buf_pad = PadWidth'(buf_q);

    for (genvar b = 0; b < NumBeats; b++) begin : g_beat_words
        assign beat_words[b] = buf_pad[b*PhyWidth +: PhyWidth];
    end

    assign last_beat   = (state_q == SEND) && (beat_q == BeatWidth'(NumBeats - 1));
    assign beat_fire   = (state_q == SEND) && phy_ready_i;
    assign ready_o     = (state_q == IDLE) || (last_beat && phy_ready_i);
    assign accept      = valid_i && ready_o;

    assign phy_valid_o = (state_q == SEND);
    assign phy_data_o  = phy_valid_o ? beat_words[beat_q] : '0;
    assign phy_last_o  = last_beat;

`ifdef FLOO_SER_PARITY_EN
    assign phy_parity_o = ^phy_data_o;
`else
    assign phy_parity_o = 1'b0;
`endif

    // A new flit is taken either from IDLE or on the last-beat handshake, so accept has priority.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            buf_q   <= '0;
            beat_q  <= '0;
        end else if (accept) begin
            state_q <= SEND;
            buf_q   <= data_i;
            beat_q  <= '0;
        end else if (beat_fire) begin
            if (last_beat) begin
                state_q <= IDLE;
                beat_q  <= '0;
            end else begin
                beat_q  <= beat_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_floo_wide_link_serializer.sv
// Scoreboard bench for floo_wide_link_serializer with FlitWidth=200, PhyWidth=64 (4 beats).
module tb_floo_wide_link_serializer;

    localparam int FW = 200;
    localparam int PW = 64;
    localparam int NB = 4;

    typedef struct packed {
        logic [PW-1:0] data;
        logic          last;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          valid_i;
    logic          ready_o;
    logic [FW-1:0] data_i;
    logic          phy_valid_o;
    logic          phy_ready_i;
    logic [PW-1:0] phy_data_o;
    logic          phy_last_o;
    logic          phy_parity_o;

    beat_t   sb_q[$];
    int      n_compared   = 0;
    int      n_mismatched = 0;
    int      flits_done   = 0;

    logic          obs_valid, obs_ready, obs_last, obs_parity;
    logic [PW-1:0] obs_data;
    logic          prev_stall = 1'b0;
    logic [PW-1:0] prev_data;
    logic          prev_last, prev_parity;
    logic          last_accept;

    floo_wide_link_serializer #(
        .FlitWidth (FW),
        .PhyWidth  (PW)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_i       (data_i),
        .phy_valid_o  (phy_valid_o),
        .phy_ready_i  (phy_ready_i),
        .phy_data_o   (phy_data_o),
        .phy_last_o   (phy_last_o),
        .phy_parity_o (phy_parity_o)
    );

    always #5 clk = ~clk;

    function automatic logic exp_parity(input logic [PW-1:0] d);
`ifdef FLOO_SER_PARITY_EN
        return ^d;
`else
        return 1'b0;
`endif
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // One cycle: drive at negedge, check against the scoreboard, then advance the scoreboard.
    task automatic applyStimulus(input logic rst, input logic v, input logic [FW-1:0] d, input logic pr);
        logic                exp_ready;
        logic                have;
        beat_t               e;
        logic [NB*PW-1:0]    pad;
        @(negedge clk);
        rst_n       = rst;
        valid_i     = v;
        data_i      = d;
        phy_ready_i = pr;
        #1;
        obs_valid  = phy_valid_o;
        obs_ready  = ready_o;
        obs_data   = phy_data_o;
        obs_last   = phy_last_o;
        obs_parity = phy_parity_o;
        have       = (sb_q.size() != 0);
        exp_ready  = !have || (sb_q.size() == 1 && pr);
        checkOutput("phy_valid", 64'(obs_valid), 64'(have));
        checkOutput("ready", 64'(obs_ready), 64'(exp_ready));
        if (have) begin
            checkOutput("phy_data", obs_data, sb_q[0].data);
            checkOutput("phy_last", 64'(obs_last), 64'(sb_q[0].last));
            checkOutput("phy_parity", 64'(obs_parity), 64'(exp_parity(sb_q[0].data)));
        end else begin
            checkOutput("idle_last", 64'(obs_last), 64'd0);
        end
        if (prev_stall) begin
            checkOutput("stall_data", obs_data, prev_data);
            checkOutput("stall_last", 64'(obs_last), 64'(prev_last));
            checkOutput("stall_parity", 64'(obs_parity), 64'(prev_parity));
        end
        prev_stall  = have && !pr && rst;
        prev_data   = obs_data;
        prev_last   = obs_last;
        prev_parity = obs_parity;
        if (have && pr) begin
            void'(sb_q.pop_front());
            if (obs_last) flits_done++;
        end
        last_accept = v && exp_ready;
        if (last_accept) begin
            pad = {{(NB*PW-FW){1'b0}}, d};
            for (int b = 0; b < NB; b++) begin
                e.data = pad[b*PW +: PW];
                e.last = (b == NB - 1);
                sb_q.push_back(e);
            end
        end
        if (!rst) begin
            sb_q.delete();
            prev_stall  = 1'b0;
            last_accept = 1'b0;
        end
    endtask

    function automatic logic [FW-1:0] rand_flit();
        logic [223:0] r;
        for (int i = 0; i < 7; i++) r[i*32 +: 32] = $urandom;
        return r[FW-1:0];
    endfunction

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [FW-1:0] f1, fa, fb, fc, fd, fp;
        logic [PW-1:0] sf_data [NB];
        logic [NB-1:0] sf_last;
        logic [7:0]    ready_mask, valid_mask;
        int            sent, cyc, k;

        rst_n       = 1'b0;
        valid_i     = 1'b1;
        data_i      = '1;
        phy_ready_i = 1'b0;
        @(posedge clk);

        // Reset held with valid_i high: nothing may be captured.
        repeat (3) applyStimulus(1'b0, 1'b1, {FW{1'b1}}, 1'b0);
        checkOutput("rst_ready", 64'(obs_ready), 64'd1);
        checkOutput("rst_valid", 64'(obs_valid), 64'd0);
        checkOutput("rst_data", obs_data, 64'd0);
        checkOutput("rst_last", 64'(obs_last), 64'd0);
        checkOutput("rst_parity", 64'(obs_parity), 64'd0);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkOutput("rst_no_capture", 64'(obs_valid), 64'd0);

        // Single flit with data only in beat 0 and the partial last beat.
        f1 = (200'hA5 << 192) | 200'h1111_2222_3333_4444;
        applyStimulus(1'b1, 1'b1, f1, 1'b1);
        for (int i = 0; i < NB; i++) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b1);
            sf_data[i] = obs_data;
            sf_last[i] = obs_last;
        end
        checkOutput("single_beat0", sf_data[0], 64'h1111_2222_3333_4444);
        checkOutput("single_beat1", sf_data[1], 64'h0);
        checkOutput("single_beat2", sf_data[2], 64'h0);
        checkOutput("single_beat3", sf_data[3], 64'h0000_0000_0000_00A5);
        checkOutput("single_last_mask", 64'(sf_last), 64'b1000);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkOutput("single_idle_after", 64'(obs_valid), 64'd0);

        // Back-to-back: ready_o pulses exactly on the last beat of each flit.
        fa = rand_flit();
        fb = rand_flit();
        applyStimulus(1'b1, 1'b1, fa, 1'b1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, (i < 7), (i < 3) ? fa : fb, 1'b1);
            ready_mask[i] = obs_ready;
            valid_mask[i] = obs_valid;
        end
        checkOutput("b2b_ready_mask", 64'(ready_mask), 64'h88);
        checkOutput("b2b_valid_mask", 64'(valid_mask), 64'hFF);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkOutput("b2b_idle_after", 64'(obs_valid), 64'd0);

        // Random backpressure and random upstream valid over 100 flits.
        flits_done = 0;
        sent = 0;
        cyc  = 0;
        while (sent < 100 && cyc < 5000) begin
            applyStimulus(1'b1, ($urandom_range(0, 3) != 0), rand_flit(), 1'($urandom_range(0, 1)));
            if (last_accept) sent++;
            cyc++;
        end
        if (sent < 100) checkOutput("rand_timeout", 64'(sent), 64'd100);
        k = 0;
        while (sb_q.size() != 0 && k < 50) begin
            applyStimulus(1'b1, 1'b0, '0, 1'b1);
            k++;
        end
        checkOutput("rand_flits_done", 64'(flits_done), 64'd100);

        // Reset while beat 2 is on the link drops the rest of the flit.
        fc = rand_flit();
        fd = rand_flit();
        applyStimulus(1'b1, 1'b1, fc, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b1);
        checkOutput("rst_mid_beat2", obs_data, fc[128 +: 64]);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkOutput("rst_mid_idle", 64'(obs_valid), 64'd0);
        checkOutput("rst_mid_ready", 64'(obs_ready), 64'd1);
        applyStimulus(1'b1, 1'b1, fd, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkOutput("after_rst_beat0", obs_data, fd[63:0]);
        repeat (4) applyStimulus(1'b1, 1'b0, '0, 1'b1);

        // Parity on beats 64'h1 and 64'h3.
        fp = (200'h3 << 64) | 200'h1;
        applyStimulus(1'b1, 1'b1, fp, 1'b1);
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
`ifdef FLOO_SER_PARITY_EN
        checkOutput("parity_one", 64'(obs_parity), 64'd1);
`else
        checkOutput("parity_one", 64'(obs_parity), 64'd0);
`endif
        applyStimulus(1'b1, 1'b0, '0, 1'b1);
        checkOutput("parity_three", 64'(obs_parity), 64'd0);
        repeat (3) applyStimulus(1'b1, 1'b0, '0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
